// File: rtl/kgp_wb_pkg.sv
// Shared types and constants for the register-file write-back port sequencer.
package kgp_wb_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] EXT_ADDR_DEF = 5'd20;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXT  = 1'b1
  } state_e;
endpackage

// File: rtl/wb_port_sequencer.sv
// Serializes core write-backs (primary + optional extended word) onto the single
// register-file write port, sharing it with a debug requester under bounded starvation.
module wb_port_sequencer
  import kgp_wb_pkg::*;
#(
  parameter logic [REG_W-1:0] EXT_ADDR     = EXT_ADDR_DEF,
  parameter int               STARVE_LIMIT = 4,
  parameter int               ZERO_GUARD   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [REG_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_ext_en,
  input  logic [DATA_W-1:0] wb_ext_data,
  input  logic              dbg_req,
  output logic              dbg_gnt,
  input  logic [REG_W-1:0]  dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [2:0]        starve_q, starve_d;
  logic [DATA_W-1:0] ext_q, ext_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic force_dbg, core_acc, dbg_acc;

  function automatic logic we_for(input logic [REG_W-1:0] a);
    return !((ZERO_GUARD != 0) && (a == '0));
  endfunction

  // Handshake depends only on state, starvation count and request strobes.
  always_comb begin
    force_dbg = dbg_req & (starve_q == LIMIT);
    wb_ready  = 1'b0;
    dbg_gnt   = 1'b0;
    if (rst_n && state_q == ST_IDLE) begin
      wb_ready = ~force_dbg;
      dbg_gnt  = dbg_req & (~wb_valid | force_dbg);
    end
    stall    = wb_valid & ~wb_ready;
    core_acc = wb_valid & wb_ready;
    dbg_acc  = dbg_req & dbg_gnt;
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    ext_d      = ext_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    if (!dbg_req || dbg_acc)
      starve_d = '0;
    else if (core_acc && starve_q != LIMIT)
      starve_d = starve_q + 3'd1;

    if (state_q == ST_EXT) begin
      rf_we_d    = we_for(EXT_ADDR);
      rf_waddr_d = EXT_ADDR;
      rf_wdata_d = ext_q;
      state_d    = ST_IDLE;
    end else if (core_acc) begin
      rf_we_d    = we_for(wb_addr);
      rf_waddr_d = wb_addr;
      rf_wdata_d = wb_data;
      if (wb_ext_en) begin
        ext_d   = wb_ext_data;
        state_d = ST_EXT;
      end
    end else if (dbg_acc) begin
      rf_we_d    = we_for(dbg_addr);
      rf_waddr_d = dbg_addr;
      rf_wdata_d = dbg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      ext_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      ext_q      <= ext_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Scoreboard bench: stimulus queues expected register-file writes, a monitor pops
// and compares them whenever rf_we pulses.
module tb_wb_port_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0, wb_ready, wb_ext_en = 1'b0;
  logic [4:0]  wb_addr = '0, dbg_addr = '0, rf_waddr;
  logic [31:0] wb_data = '0, wb_ext_data = '0, dbg_data = '0, rf_wdata;
  logic        dbg_req = 1'b0, dbg_gnt, rf_we, stall;

  int n_chk = 0, n_pass = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  wb_port_sequencer #(.EXT_ADDR(5'd20), .STARVE_LIMIT(4), .ZERO_GUARD(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ext_en(wb_ext_en), .wb_ext_data(wb_ext_data),
    .dbg_req(dbg_req), .dbg_gnt(dbg_gnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall(stall)
  );

  task automatic chk(input string nm, input logic [36:0] act, input logic [36:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", {rf_waddr, rf_wdata}, 37'h0);
      else chk("rf_write", {rf_waddr, rf_wdata}, exp_q.pop_front());
    end
  end

  // One cycle: check handshake against hand-computed values, queue implied writes.
  task automatic step(input string nm, input logic er, input logic eg, input logic es);
    @(negedge clk);
    chk({nm, "_ready"}, 37'(wb_ready), 37'(er));
    chk({nm, "_gnt"},   37'(dbg_gnt),  37'(eg));
    chk({nm, "_stall"}, 37'(stall),    37'(es));
    if (wb_valid && er) begin
      if (wb_addr != 0) exp_q.push_back({wb_addr, wb_data});
      if (wb_ext_en)    exp_q.push_back({5'd20, wb_ext_data});
    end
    if (dbg_req && eg && dbg_addr != 0) exp_q.push_back({dbg_addr, dbg_data});
    @(posedge clk); #1;
  endtask

  task automatic core(input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic e, input logic [31:0] ed);
    wb_valid = v; wb_addr = a; wb_data = d; wb_ext_en = e; wb_ext_data = ed;
  endtask

  initial begin
    wb_valid = 1'b1;
    #12;
    chk("rst_we",    37'(rf_we),    37'h0);
    chk("rst_addr",  37'(rf_waddr), 37'h0);
    chk("rst_data",  37'(rf_wdata), 37'h0);
    chk("rst_ready", 37'(wb_ready), 37'h0);
    chk("rst_gnt",   37'(dbg_gnt),  37'h0);
    chk("rst_stall", 37'(stall),    37'h1);
    wb_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back single writes.
    core(1, 5'd5, 32'hDEAD_BEEF, 0, 0);  step("single0", 1, 0, 0);
    core(1, 5'd6, 32'h0000_1234, 0, 0);  step("single1", 1, 0, 0);
    core(0, 0, 0, 0, 0);                 step("idle0",   1, 0, 0);

    // Extended write; debug asks during EXT and must wait.
    core(1, 5'd3, 32'h1, 1, 32'hFFFF_0000); step("ext_acc", 1, 0, 0);
    core(1, 5'd4, 32'h2, 0, 0);
    dbg_req = 1; dbg_addr = 5'd31; dbg_data = 32'd9;
    step("ext_busy", 0, 0, 1);
    step("ext_next", 1, 0, 0);
    core(0, 0, 0, 0, 0);                 step("dbg_idle", 1, 1, 0);
    dbg_req = 0;                         step("idle1",    1, 0, 0);

    // Starvation: four core accepts, then debug forced a slot.
    dbg_req = 1; dbg_addr = 5'd7; dbg_data = 32'h77;
    for (int i = 0; i < 4; i++) begin
      core(1, 5'(10 + i), 32'(100 + i), 0, 0);
      step("starve_core", 1, 0, 0);
    end
    core(1, 5'd15, 32'h555, 0, 0);       step("starve_force", 0, 1, 1);
    dbg_req = 0;                         step("starve_resume", 1, 0, 0);
    core(0, 0, 0, 0, 0);                 step("idle2", 1, 0, 0);

    // Zero guard: r0 writes are suppressed, EXT still writes r20.
    core(1, 5'd0, 32'd5, 0, 0);          step("zero_single", 1, 0, 0);
    core(1, 5'd0, 32'd6, 1, 32'hABCD);   step("zero_ext",    1, 0, 0);
    core(0, 0, 0, 0, 0);                 step("zero_extcyc", 0, 0, 0);
    step("idle3", 1, 0, 0);

    // Reset during EXT: pending r20 write must be dropped.
    core(1, 5'd9, 32'h99, 1, 32'hBAD0_BAD0);
    @(negedge clk);
    chk("rstx_ready", 37'(wb_ready), 37'h1);
    @(posedge clk); #1;
    core(0, 0, 0, 0, 0);
    chk("rstx_prim", {rf_we, rf_waddr, rf_wdata[30:0]}, {1'b1, 5'd9, 31'h99});
    rst_n = 0; #1;
    chk("rstx_we", 37'(rf_we), 37'h0);
    wb_valid = 1; #1;
    chk("rstx_stall", 37'(stall), 37'h1);
    wb_valid = 0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    step("rstx_idle", 1, 0, 0);
    core(1, 5'd12, 32'hC0DE, 0, 0);      step("rstx_reissue", 1, 0, 0);
    core(0, 0, 0, 0, 0);                 step("idle4", 1, 0, 0);
    step("idle5", 1, 0, 0);

    chk("queue_drained", 37'(exp_q.size()), 37'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
